pipelined_cla_adder: RTL
========================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of BLOCK.
REQ-002 Parameter BLOCK, default 4, bits per carry-lookahead slice; NSEG = WIDTH/BLOCK pipeline segments.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_valid  input  1  operand set present on i_add1/i_add2/i_sub.
REQ-006 o_in_ready  output  1  block can accept an operand set this cycle.
REQ-007 i_add1  input  WIDTH  first operand.
REQ-008 i_add2  input  WIDTH  second operand.
REQ-009 i_sub  input  1  0 = add, 1 = subtract (i_add1 - i_add2).
REQ-010 o_valid  output  1  o_result/o_overflow hold a completed operation.
REQ-011 i_out_ready  input  1  downstream accepts the current result.
REQ-012 o_result  output  WIDTH+1  sum/difference; bit WIDTH is carry-out.
REQ-013 o_overflow  output  1  two's-complement signed overflow of the WIDTH-bit result.

Function
REQ-014 Add SHALL compute i_add1 + i_add2 + 0; subtract SHALL compute i_add1 + ~i_add2 + 1. Carry-out goes to o_result[WIDTH], so on subtract 1 = no borrow and 0 = borrow.
REQ-015 Each segment k (0..NSEG-1) SHALL resolve bits [k*BLOCK +: BLOCK] with generate/propagate carry lookahead inside the slice. It SHALL register the slice sum, the slice carry-out, the not-yet-added upper operand bits and the mode bit.
REQ-016 No ripple SHALL cross a segment boundary within one cycle. Worst-case combinational path = one BLOCK-bit lookahead slice.
REQ-017 Advance: adv = !o_valid || i_out_ready; o_in_ready = adv. All segment registers, including valid bits, SHALL load only when adv = 1 and otherwise hold their value.
REQ-018 Accepting a transfer: i_valid && o_in_ready. The valid bit entering segment 0 = i_valid && adv. Non-accepted cycles insert bubbles.
REQ-019 Latency SHALL be exactly NSEG cycles from acceptance to o_valid = 1 when no stall occurs. Throughput SHALL be one operation per cycle.
REQ-020 Results SHALL emerge in acceptance order. None SHALL be dropped or duplicated.
REQ-021 While o_valid = 1 and i_out_ready = 0, o_result, o_overflow and o_valid SHALL stay stable.
REQ-022 o_overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-023 Operand values on cycles with i_valid = 0 or o_in_ready = 0 SHALL NOT affect any delivered result.
REQ-024 If NSEG = 1, the block SHALL degenerate to a single registered CLA with latency 1, using the same handshake.

Reset
REQ-025 i_rst = 1 SHALL clear all segment valid bits, o_valid, o_result and o_overflow to 0 immediately, without waiting for i_clk.
REQ-026 o_in_ready SHALL read 1 during and after reset, because o_valid = 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operations. After release, no stale result SHALL appear.
REQ-028 The first rising edge after reset release SHALL be able to accept an operand set.

Verification (WIDTH=16, BLOCK=4, latency 4)
REQ-029 Add 0xFFFF + 0x0001, i_out_ready=1 -> after 4 cycles o_valid=1, o_result=0x10000, o_overflow=0.
REQ-030 Add 0x7FFF + 0x0001 -> o_result=0x08000, o_overflow=1. Sub 0x8000 - 0x0001 -> o_result=0x17FFF, o_overflow=1.
REQ-031 Sub 0x0005 - 0x0007 -> o_result=0x0FFFE (borrow, bit16=0), o_overflow=0. Sub 0x0007 - 0x0005 -> o_result=0x10002.
REQ-032 Stream 100 random add/sub sets back-to-back, with i_out_ready toggling randomly -> every result matches the golden model in order, and outputs stay stable while stalled.
REQ-033 Hold i_out_ready=0 with the pipeline full -> o_in_ready=0 and no input is accepted. Release it -> results drain at one per cycle.
REQ-034 Assert i_rst asynchronously between edges with 3 operations in flight -> o_valid=0 and o_result=0 immediately. After release, o_valid stays 0 until a new operation completes 4 cycles after acceptance.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract: one BLOCK-bit lookahead slice per stage, carry registered between stages.
// Latency WIDTH/BLOCK cycles, one op per cycle; the whole pipe freezes while the output is held.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_out_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_overflow
);

    localparam int NSEG = WIDTH / BLOCK;

    logic adv;

    assign adv        = !o_valid || i_out_ready;
    assign o_in_ready = adv;

    // Flattened sum-of-products lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    function automatic logic [BLOCK:0] cla_carries(
        input logic [BLOCK-1:0] g,
        input logic [BLOCK-1:0] p,
        input logic             cin
    );
        logic [BLOCK:0] c;
        logic           t;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            t = cin;
            for (int m = 0; m <= i; m++) t = t & p[m];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) t = t & p[m];
                c[i+1] = c[i+1] | t;
            end
        end
        return c;
    endfunction

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int SRC = WIDTH - k * BLOCK;   // operand bits not yet added
        localparam int LO  = k * BLOCK;           // result bits already resolved

        logic [SRC-1:0]      src_a;
        logic [SRC-1:0]      src_b;
        logic                src_cin;
        logic                src_mode;
        logic                src_vld;
        logic [LO+BLOCK-1:0] sum_d;

        logic [BLOCK-1:0]    x;
        logic [BLOCK-1:0]    y;
        logic [BLOCK-1:0]    gen;
        logic [BLOCK-1:0]    prop;
        logic [BLOCK:0]      c;
        logic [BLOCK-1:0]    s;

        logic                vld_q;
        logic                cout_q;
        logic [LO+BLOCK-1:0] sum_q;

        if (k == 0) begin : g_head
            assign src_a    = i_add1;
            assign src_b    = i_add2;
            assign src_cin  = i_sub;
            assign src_mode = i_sub;
            assign src_vld  = i_valid && adv;
            assign sum_d    = s;
        end else begin : g_body
            assign src_a    = g_seg[k-1].g_fwd.rem_a;
            assign src_b    = g_seg[k-1].g_fwd.rem_b;
            assign src_cin  = g_seg[k-1].cout_q;
            assign src_mode = g_seg[k-1].g_fwd.mode_q;
            assign src_vld  = g_seg[k-1].vld_q;
            assign sum_d    = {s, g_seg[k-1].sum_q};
        end

        // Subtract is a + ~b + 1; the +1 enters as the stage-0 carry-in
        assign x    = src_a[BLOCK-1:0];
        assign y    = src_b[BLOCK-1:0] ^ {BLOCK{src_mode}};
        assign gen  = x & y;
        assign prop = x ^ y;
        assign c    = cla_carries(gen, prop, src_cin);
        assign s    = prop ^ c[BLOCK-1:0];

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                vld_q  <= 1'b0;
                cout_q <= 1'b0;
                sum_q  <= '0;
            end else if (adv) begin
                vld_q  <= src_vld;
                cout_q <= c[BLOCK];
                sum_q  <= sum_d;
            end
        end

        if (k < NSEG - 1) begin : g_fwd
            logic [SRC-BLOCK-1:0] rem_a;
            logic [SRC-BLOCK-1:0] rem_b;
            logic                 mode_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    rem_a  <= '0;
                    rem_b  <= '0;
                    mode_q <= 1'b0;
                end else if (adv) begin
                    rem_a  <= src_a[SRC-1:BLOCK];
                    rem_b  <= src_b[SRC-1:BLOCK];
                    mode_q <= src_mode;
                end
            end
        end else begin : g_tail
            logic ovf_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= c[BLOCK] ^ c[BLOCK-1];
                end
            end
        end
    end

    assign o_valid    = g_seg[NSEG-1].vld_q;
    assign o_result   = {g_seg[NSEG-1].cout_q, g_seg[NSEG-1].sum_q};
    assign o_overflow = g_seg[NSEG-1].g_tail.ovf_q;

endmodule
